// File: rtl/temp_adc_reader.sv
// temp_adc_reader: periodically runs one LTC2308 SPI conversion on a fixed
// single-ended channel and presents the 12-bit result with a one-cycle
// valid strobe for the temperature PIO.
module temp_adc_reader #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int CHANNEL       = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    output logic [11:0] temp_out,
    output logic        temp_valid,
    output logic        busy
);

    localparam int PERIOD_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CNT_MAX  = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;

    // ADC config word: single-ended, unipolar, no sleep, channel bits in
    // the LTC2308's odd/select order.
    localparam logic [2:0] CH  = 3'(CHANNEL);
    localparam logic [5:0] CFG = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    logic [PERIOD_W-1:0]  period_cnt;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic [11:0]          shreg;
    logic [4:0]           sdi_sr;
    logic                 first_frame;
    logic                 start_req;

    assign start_req = (period_cnt == '0);

    // Free-running sample-period counter; runs whether or not enable is set.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in a clocked block sees the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (period_cnt == PERIOD_W'(SAMPLE_PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Conversion/readout sequencer with registered ADC pins and outputs.
    // NOTE: the shift register and counters are plain flops (not a memory),
    // so they sit on the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            sdi_sr      <= '0;
            first_frame <= 1'b1;
            adc_convst  <= 1'b0;
            adc_sck     <= 1'b0;
            adc_sdi     <= 1'b0;
            temp_out    <= '0;
            temp_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A request seen while disabled is simply dropped.
                    if (start_req && enable) begin
                        state      <= CONV;
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                        adc_sdi    <= CFG[5];
                        busy       <= 1'b1;
                    end
                end

                CONV: begin
                    if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        adc_convst <= 1'b0;
                        adc_sdi    <= CFG[5];
                        sdi_sr     <= CFG[4:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!adc_sck) begin
                            // Rising SCK: the ADC bit has been stable since
                            // the previous falling edge, capture MSB first.
                            adc_sck <= 1'b1;
                            shreg   <= {shreg[10:0], adc_sdo};
                        end else begin
                            adc_sck <= 1'b0;
                            if (bit_idx == 4'd11) begin
                                state   <= DONE;
                                adc_sdi <= 1'b0;
                                // Power-on config governed the first frame,
                                // so that result is never published.
                                if (!first_frame) begin
                                    temp_out   <= shreg;
                                    temp_valid <= 1'b1;
                                end
                            end else begin
                                // Config bits run out after six periods and
                                // zeros follow.
                                bit_idx <= bit_idx + 1'b1;
                                adc_sdi <= sdi_sr[4];
                                sdi_sr  <= {sdi_sr[3:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    first_frame <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
